// File: rtl/sic_driver.sv
// rtl/sic_driver.sv - SIC transmit driver: walks x1/x2 one bit at a time, returns synchronized z (optional: SIC_DRIVER_STABLE_EN)
module sic_driver #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_target,
    input  logic       req_order,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_z,
    input  logic       z,
    output logic       x1,
    output logic       x2,
`ifdef SIC_DRIVER_STABLE_EN
    output logic       resp_unstable,
`endif
    output logic       busy
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD1, HOLD2, RESP} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             z_meta, z_s;
    logic             second_x1;
    logic             accept;
    logic [1:0]       diff;
    logic             cnt_zero;
    logic             hold_load;

    assign accept    = (state == IDLE) && req_valid;
    assign diff      = req_target ^ {x1, x2};
    assign cnt_zero  = (cnt == '0);
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign hold_load = (state != state_nx) && ((state_nx == HOLD1) || (state_nx == HOLD2));

    // Two-flop synchronizer for the asynchronous z from the SIC machine
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_meta <= 1'b0;
            z_s    <= 1'b0;
        end else begin
            z_meta <= z;
            z_s    <= z_meta;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state: two-bit moves pass through HOLD1 so the bits flip on separate edges
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (req_valid) state_nx = (diff == 2'b11) ? HOLD1 : HOLD2;
            HOLD1: if (cnt_zero) state_nx = HOLD2;
            HOLD2: if (cnt_zero) state_nx = RESP;
            RESP:  if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Hold counter: reloads on entry to a hold state, then counts down to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (hold_load) begin
            cnt <= HOLD_LOAD;
        end else if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // x1/x2 drive: at most one bit flips per edge; the deferred bit is remembered in second_x1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x1        <= 1'b0;
            x2        <= 1'b0;
            second_x1 <= 1'b0;
        end else if (accept) begin
            case (diff)
                2'b10: x1 <= ~x1;
                2'b01: x2 <= ~x2;
                2'b11: begin
                    if (req_order) begin
                        x2        <= ~x2;
                        second_x1 <= 1'b1;
                    end else begin
                        x1        <= ~x1;
                        second_x1 <= 1'b0;
                    end
                end
                default: ;
            endcase
        end else if ((state == HOLD1) && cnt_zero) begin
            if (second_x1) x1 <= ~x1;
            else           x2 <= ~x2;
        end
    end

    // Response register: captured at the end of the last hold, held until the handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            resp_z     <= 1'b0;
        end else if ((state == HOLD2) && cnt_zero) begin
            resp_valid <= 1'b1;
            resp_z     <= z_s;
        end else if ((state == RESP) && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

`ifdef SIC_DRIVER_STABLE_EN
    logic z_prev;
    logic unstable_acc;

    // Flags any z_s movement over the final HOLD2 window and reports it alongside the response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_prev        <= 1'b0;
            unstable_acc  <= 1'b0;
            resp_unstable <= 1'b0;
        end else begin
            z_prev <= z_s;
            if (hold_load && (state_nx == HOLD2)) begin
                unstable_acc <= 1'b0;
            end else if ((state == HOLD2) && (z_s != z_prev)) begin
                unstable_acc <= 1'b1;
            end
            if ((state == HOLD2) && cnt_zero) begin
                resp_unstable <= unstable_acc | (z_s != z_prev);
            end else if ((state == RESP) && resp_ready) begin
                resp_unstable <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sic_driver.sv
// tb/tb_sic_driver.sv - directed self-checking bench for sic_driver with a behavioural SIC detector
module tb_sic_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_target = 2'b00;
    logic       req_order = 1'b0;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic       resp_z;
    logic       z;
    logic       x1, x2;
    logic       busy;
`ifdef SIC_DRIVER_STABLE_EN
    logic       resp_unstable;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    sic_driver #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .req_order  (req_order),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_z     (resp_z),
        .z          (z),
        .x1         (x1),
        .x2         (x2),
`ifdef SIC_DRIVER_STABLE_EN
        .resp_unstable (resp_unstable),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // SIC machine model: z=1 only when the last three distinct inputs were 00 -> 10 -> 11
    logic [1:0] h0 = 2'b00, h1 = 2'b00, h2 = 2'b00;
    always @(x1 or x2 or rst) begin
        if (!rst) begin
            h0 = 2'b00; h1 = 2'b00; h2 = 2'b00;
        end else if ({x1, x2} != h0) begin
            h2 = h1; h1 = h0; h0 = {x1, x2};
        end
    end
    assign z = (h2 == 2'b00) && (h1 == 2'b10) && (h0 == 2'b11);

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Double-change monitor, skipping intervals that contain a reset
    logic [1:0] mon_prev = 2'b00;
    bit rst_seen = 1'b0;
    always @(negedge rst) rst_seen = 1'b1;
    always @(negedge clk) begin
        if (rst && !rst_seen)
            check("no_double_change", (({x1, x2} ^ mon_prev) == 2'b11), 1'b0);
        mon_prev = {x1, x2};
        rst_seen = 1'b0;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] t, input logic o);
        req_target = t;
        req_order  = o;
        req_valid  = 1'b1;
        tick(1);
        req_valid  = 1'b0;
    endtask

    task automatic wait_resp(input string tag, output logic zv);
        int k = 0;
        while (!resp_valid && k < 50) begin
            tick(1);
            k++;
        end
        check({tag, "_resp_seen"}, resp_valid, 1'b1);
        zv = resp_z;
        resp_ready = 1'b1;
        tick(1);
        resp_ready = 1'b0;
        check({tag, "_resp_cleared"}, resp_valid, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    logic zv;

    initial begin
        // 1. reset state
        tick(2);
        check("rst_x1", x1, 1'b0);
        check("rst_x2", x2, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b1;
        tick(1);
        check("post_rst_req_ready", req_ready, 1'b1);
        rst = 1'b0;
        #1;
        check("idle_rst_x1", x1, 1'b0);
        check("idle_rst_busy", busy, 1'b0);
        tick(1);
        rst = 1'b1;
        tick(1);

        // 2. single-bit request 00 -> 01
        send(2'b01, 1'b0);
        check("t2_e0_x1", x1, 1'b0);
        check("t2_e0_x2", x2, 1'b1);
        check("t2_e0_busy", busy, 1'b1);
        check("t2_e0_req_ready", req_ready, 1'b0);
        tick(3);
        check("t2_e3_resp_valid", resp_valid, 1'b0);
        tick(1);
        check("t2_e4_resp_valid", resp_valid, 1'b1);
        check("t2_e4_resp_z", resp_z, 1'b0);
`ifdef SIC_DRIVER_STABLE_EN
        check("t2_e4_unstable", resp_unstable, 1'b0);
`endif
        resp_ready = 1'b1;
        tick(1);
        resp_ready = 1'b0;
        check("t2_hs_resp_valid", resp_valid, 1'b0);
        check("t2_hs_req_ready", req_ready, 1'b1);
        check("t2_hs_busy", busy, 1'b0);

        // 3. two-bit requests, both orders
        send(2'b00, 1'b0);
        wait_resp("t3_back00", zv);
        send(2'b11, 1'b0);
        check("t3a_e0_x1", x1, 1'b1);
        check("t3a_e0_x2", x2, 1'b0);
        tick(3);
        check("t3a_e3_x2", x2, 1'b0);
        tick(1);
        check("t3a_e4_x2", x2, 1'b1);
        check("t3a_e4_resp_valid", resp_valid, 1'b0);
        tick(3);
        check("t3a_e7_resp_valid", resp_valid, 1'b0);
        tick(1);
        check("t3a_e8_resp_valid", resp_valid, 1'b1);
        wait_resp("t3a", zv);
        send(2'b00, 1'b0);
        wait_resp("t3_back00b", zv);
        check("t3_back00_x1", x1, 1'b0);
        check("t3_back00_x2", x2, 1'b0);
        send(2'b11, 1'b1);
        check("t3b_e0_x1", x1, 1'b0);
        check("t3b_e0_x2", x2, 1'b1);
        tick(4);
        check("t3b_e4_x1", x1, 1'b1);
        tick(3);
        check("t3b_e7_resp_valid", resp_valid, 1'b0);
        tick(1);
        check("t3b_e8_resp_valid", resp_valid, 1'b1);
        wait_resp("t3b", zv);

        // 4. sequences on the SIC machine
        do_reset();
        send(2'b10, 1'b0);
        wait_resp("t4a1", zv);
        check("t4a1_z", zv, 1'b0);
        send(2'b11, 1'b0);
        wait_resp("t4a2", zv);
        check("t4a2_z", zv, 1'b1);
        do_reset();
        send(2'b10, 1'b0);
        wait_resp("t4b1", zv);
        check("t4b1_z", zv, 1'b0);
        send(2'b11, 1'b0);
        wait_resp("t4b2", zv);
        check("t4b2_z", zv, 1'b1);
        send(2'b10, 1'b0);
        wait_resp("t4b3", zv);
        check("t4b3_z", zv, 1'b0);
        send(2'b11, 1'b0);
        wait_resp("t4b4", zv);
        check("t4b4_z", zv, 1'b0);

        // 5. response backpressure with ignored requests
        do_reset();
        send(2'b10, 1'b0);
        wait_resp("t5a", zv);
        send(2'b11, 1'b0);
        for (int k = 0; k < 10 && !resp_valid; k++) tick(1);
        check("t5_resp_seen", resp_valid, 1'b1);
        req_target = 2'b00;
        for (int i = 0; i < 10; i++) begin
            req_valid = ~req_valid;
            tick(1);
            check("t5_hold_resp_valid", resp_valid, 1'b1);
            check("t5_hold_resp_z", resp_z, 1'b1);
            check("t5_hold_req_ready", req_ready, 1'b0);
            check("t5_hold_x1", x1, 1'b1);
            check("t5_hold_x2", x2, 1'b1);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick(1);
        resp_ready = 1'b0;
        check("t5_rel_resp_valid", resp_valid, 1'b0);
        check("t5_rel_req_ready", req_ready, 1'b1);
        check("t5_rel_busy", busy, 1'b0);
        tick(2);
        check("t5_noqueue_x1", x1, 1'b1);
        check("t5_noqueue_x2", x2, 1'b1);
        check("t5_noqueue_busy", busy, 1'b0);

        // 6. reset during HOLD1, then normal request
        do_reset();
        send(2'b11, 1'b0);
        tick(1);
        check("t6_hold1_x1", x1, 1'b1);
        check("t6_hold1_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("t6_rst_x1", x1, 1'b0);
        check("t6_rst_x2", x2, 1'b0);
        check("t6_rst_resp_valid", resp_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_req_ready", req_ready, 1'b1);
        tick(2);
        rst = 1'b1;
        tick(1);
        send(2'b01, 1'b0);
        tick(3);
        check("t6_e3_resp_valid", resp_valid, 1'b0);
        tick(1);
        check("t6_e4_resp_valid", resp_valid, 1'b1);
        check("t6_e4_resp_z", resp_z, 1'b0);
        check("t6_e4_x1", x1, 1'b0);
        check("t6_e4_x2", x2, 1'b1);
        wait_resp("t6", zv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sic_driver.md
Name: sic_driver

Overview:
- Transmit end of the single-input-change (SIC) interface: drives the x1/x2 pair into an SIC sequence-detector machine and returns its z response.
- Accepts a target input word per request and walks x1/x2 to it one bit at a time, never changing both in the same cycle.
- Holds each intermediate value for a settle time, then samples a synchronized z and returns it over a valid/ready response channel.
- Used by test and control logic to apply input sequences such as 00->01->11->01->11.

Parameters:
- HOLD_CYCLES, 4: cycles each new x1/x2 value is held before the next change or the z sample. Legal range is 3 to 2^CNT_W-1.
- CNT_W, 8: width of the hold counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_target  in  2  target word; [1] maps to x1, [0] maps to x2.
- req_order  in  1  path when both bits differ: 0 = flip x1 first, 1 = flip x2 first.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed.
- resp_z  out  1  sampled z for the completed request.
- z  in  1  asynchronous output of the SIC machine.
- x1  out  1  SIC input 1, registered.
- x2  out  1  SIC input 2, registered.
- busy  out  1  high whenever not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): x1=0, x2=0, resp_valid=0, resp_z=0, busy=0, state=IDLE, counter=0, synchronizer flops=0. req_ready=1 once IDLE.
- z passes through a 2-flop synchronizer to form z_s.
- req_ready = (state==IDLE). Requests are accepted only in IDLE.
- States: IDLE, HOLD1, HOLD2, RESP.
- Accept edge E0: compute d = req_target ^ {x1,x2}.
  - d=00: x unchanged; go to HOLD2.
  - d=10 or d=01: flip the differing bit at E0; go to HOLD2.
  - d=11: flip the first bit per req_order at E0; go to HOLD1 and latch the second bit.
- At entry to HOLD1 or HOLD2, the counter loads HOLD_CYCLES-1 and decrements each cycle.
- HOLD1 at count 0 (edge E0+HOLD_CYCLES): flip the latched second bit; go to HOLD2.
- HOLD2 at count 0: resp_z <= z_s, resp_valid <= 1; go to RESP.
- Response timing relative to E0:
  - single-bit or no-change request: response at E0+HOLD_CYCLES.
  - two-bit request: response at E0+2*HOLD_CYCLES.
- RESP: resp_valid and resp_z stay stable until resp_valid & resp_ready. On that edge resp_valid=0 and state=IDLE; req_ready=1 the following cycle.
- Invariant: x1 and x2 never change on the same clock edge. Only reset may change both.
- req_valid outside IDLE is ignored; a request is never queued.
- Reset mid-operation: immediate return to reset values; the in-flight request and response are discarded.
- Counter width: HOLD_CYCLES-1 must fit in CNT_W. No wrap occurs within legal range.

Optional Feature:
- SIC_DRIVER_STABLE_EN defined:
  - Adds output port resp_unstable (1 bit, reset 0).
  - resp_unstable is set with resp_valid if z_s changed during any cycle of the final HOLD2 window; otherwise 0.
  - It is held with the response and cleared on the handshake.
- Not defined: no port, no check logic; timing is identical.

Test Plan:
1. Assert then release rst: x1=0, x2=0, req_ready=1, resp_valid=0, busy=0. Drop rst during idle -> same values asynchronously.
2. HOLD_CYCLES=4, from 00 request target 01: x2=1 at E0, x1 stays 0; resp_valid=1 at E0+4. With the SIC machine attached, resp_z=0.
3. From 00 request 11 with req_order=0: x1=1 at E0, x2=1 at E0+4, resp_valid at E0+8. Monitor confirms no double change. Repeat with req_order=1: x2 flips first.
4. Sequence 00->10->11 (two single-bit requests) on the SIC machine -> second resp_z=1. Sequence 00->10->11->10->11 -> final resp_z=0.
5. Hold resp_ready=0 for 10 cycles while pulsing req_valid: resp_valid and resp_z stable, req_ready=0, x unchanged. Release resp_ready -> IDLE next edge.
6. Pull rst low during HOLD1 of a request 11 -> x=00, resp_valid=0, busy=0 immediately. After release, a request for 01 completes normally at E0+4.
